// File: rtl/wb_stage_pkg.sv
// Shared constants for the b-risc writeback stage: source selects, load funct3 codes, FSM states.
package wb_stage_pkg;
  localparam int DEST_SRC_W = 2;

  localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE = 2'd0;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_ALU  = 2'd1;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_MEM  = 2'd2;
  localparam logic [DEST_SRC_W-1:0] DEST_SRC_LINK = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [0:0] WB_ST_IDLE     = 1'b0;
  localparam logic [0:0] WB_ST_WAIT_MEM = 1'b1;
endpackage

// File: rtl/wb_stage_if.sv
// Upstream handshake, load-return and register-file write bundle of the writeback stage.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int WORD_W    = 32,
  parameter int REG_IDX_W = 5
) ();
  logic                  i_valid;
  logic                  o_ready;
  logic [ADDR_W-1:0]     i_pc;
  logic [INSTR_W-1:0]    i_instr;
  logic [DEST_SRC_W-1:0] i_dest_src;
  logic [REG_IDX_W-1:0]  i_dest_reg;
  logic [WORD_W-1:0]     i_alu_eval;
  logic                  i_mem_rvalid;
  logic [WORD_W-1:0]     i_mem_rdata;
  logic                  o_dest_en;
  logic [REG_IDX_W-1:0]  o_dest_reg;
  logic [WORD_W-1:0]     o_dest_data;
  logic                  o_retire;

  modport slave (
    input  i_valid, i_pc, i_instr, i_dest_src, i_dest_reg, i_alu_eval,
           i_mem_rvalid, i_mem_rdata,
    output o_ready, o_dest_en, o_dest_reg, o_dest_data, o_retire
  );

  modport master (
    output i_valid, i_pc, i_instr, i_dest_src, i_dest_reg, i_alu_eval,
           i_mem_rvalid, i_mem_rdata,
    input  o_ready, o_dest_en, o_dest_reg, o_dest_data, o_retire
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// wb_load_ext: combinational byte/half/word select and sign/zero extension of a returned load word.
module wb_load_ext
  import wb_stage_pkg::*;
#(
  parameter int WORD_W = 32,
  localparam int LANE_W = $clog2(WORD_W/8)
) (
  input  logic [WORD_W-1:0] i_rdata,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [2:0]        i_funct3,
  output logic [WORD_W-1:0] o_data
);
  logic [LANE_W-1:0] w_off;
  logic [WORD_W-1:0] w_shift;

  always_comb begin
    w_off = i_lane;
    case (i_funct3)
      F3_LH, F3_LHU: w_off = i_lane & ~LANE_W'(1);
      F3_LW, F3_LWU: w_off = i_lane & ~LANE_W'(3);
      default:       w_off = i_lane;
    endcase
    w_shift = i_rdata >> {w_off, 3'b000};
    case (i_funct3)
      F3_LB:   o_data = WORD_W'($signed(w_shift[7:0]));
      F3_LBU:  o_data = WORD_W'(w_shift[7:0]);
      F3_LH:   o_data = WORD_W'($signed(w_shift[15:0]));
      F3_LHU:  o_data = WORD_W'(w_shift[15:0]);
      F3_LW:   o_data = WORD_W'($signed(w_shift[31:0]));
      F3_LWU:  o_data = WORD_W'(w_shift[31:0]);
      default: o_data = i_rdata;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU/LINK retire in 1 cycle, loads wait for rvalid; ready only while IDLE.
// Optional retire counter on o_retire_cnt when WB_RETIRE_CNT_EN is defined.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int WORD_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  wb_stage_if.slave        wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] o_retire_cnt
`endif
);
  localparam int LANE_W = $clog2(WORD_W/8);

  logic [0:0]            r_state;
  logic [ADDR_W-1:0]     r_pc;
  logic [INSTR_W-1:0]    r_instr;
  logic [DEST_SRC_W-1:0] r_src;
  logic [REG_IDX_W-1:0]  r_reg;
  logic [WORD_W-1:0]     r_eval;
  logic                  r_dest_en;
  logic [REG_IDX_W-1:0]  r_dest_reg;
  logic [WORD_W-1:0]     r_dest_data;
  logic                  r_retire;

  logic                  w_accept;
  logic [WORD_W-1:0]     w_link;
  logic [WORD_W-1:0]     w_ext;
  logic                  w_unused_bits;

  assign wb.o_ready    = (r_state == WB_ST_IDLE);
  assign w_accept      = wb.i_valid & wb.o_ready;
  assign w_link        = WORD_W'(wb.i_pc + ADDR_W'(4));
  assign w_unused_bits = ^{r_pc, r_instr[INSTR_W-1:15], r_instr[11:0], r_src,
                           r_eval[WORD_W-1:LANE_W]};

  wb_load_ext #(.WORD_W(WORD_W)) u_load_ext (
    .i_rdata  (wb.i_mem_rdata),
    .i_lane   (r_eval[LANE_W-1:0]),
    .i_funct3 (r_instr[14:12]),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= WB_ST_IDLE;
      r_pc        <= '0;
      r_instr     <= '0;
      r_src       <= DEST_SRC_NONE;
      r_reg       <= '0;
      r_eval      <= '0;
      r_dest_en   <= 1'b0;
      r_dest_reg  <= '0;
      r_dest_data <= '0;
      r_retire    <= 1'b0;
    end else begin
      r_dest_en <= 1'b0;
      r_retire  <= 1'b0;
      case (r_state)
        WB_ST_IDLE: begin
          if (w_accept) begin
            r_pc    <= wb.i_pc;
            r_instr <= wb.i_instr;
            r_src   <= wb.i_dest_src;
            r_reg   <= wb.i_dest_reg;
            r_eval  <= wb.i_alu_eval;
            if (wb.i_dest_src == DEST_SRC_MEM) begin
              r_state <= WB_ST_WAIT_MEM;
            end else begin
              r_retire <= 1'b1;
              if (wb.i_dest_src != DEST_SRC_NONE && wb.i_dest_reg != '0) begin
                r_dest_en   <= 1'b1;
                r_dest_reg  <= wb.i_dest_reg;
                r_dest_data <= (wb.i_dest_src == DEST_SRC_LINK) ? w_link : wb.i_alu_eval;
              end
            end
          end
        end
        default: begin
          // Occupancy is unbounded: the stage holds until the memory returns.
          if (wb.i_mem_rvalid) begin
            r_state  <= WB_ST_IDLE;
            r_retire <= 1'b1;
            if (r_reg != '0) begin
              r_dest_en   <= 1'b1;
              r_dest_reg  <= r_reg;
              r_dest_data <= w_ext;
            end
          end
        end
      endcase
    end
  end

  assign wb.o_dest_en   = r_dest_en;
  assign wb.o_dest_reg  = r_dest_reg;
  assign wb.o_dest_data = r_dest_data;
  assign wb.o_retire    = r_retire;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_retire_cnt <= '0;
    end else if (r_retire) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign o_retire_cnt = r_retire_cnt;
`else
  localparam int UNUSED_CNT_W = CNT_W;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Directed and randomized bench for wb_stage against a behavioural writeback model.
module tb_wb_stage;
  import wb_stage_pkg::*;

`ifdef WB_RETIRE_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  logic [4:0]  last_reg  = '0;
  logic [31:0] last_data = '0;

  wb_stage_if #(.ADDR_W(32), .INSTR_W(32), .WORD_W(32), .REG_IDX_W(5)) bus ();

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  wb_stage #(.ADDR_W(32), .INSTR_W(32), .WORD_W(32), .REG_IDX_W(5), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .wb    (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .o_retire_cnt (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                           input logic [2:0] f3);
    longint v;
    int     lane;
    lane = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((w >> (8 * lane)) % 256);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((w >> (16 * (lane / 2))) % 65536);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  task automatic issue(input logic [1:0] src, input logic [4:0] rg, input logic [31:0] eval,
                       input logic [31:0] pc, input logic [2:0] f3);
    logic [31:0] instr;
    instr = $urandom;
    instr[14:12] = f3;
    bus.i_valid    = 1'b1;
    bus.i_dest_src = src;
    bus.i_dest_reg = rg;
    bus.i_alu_eval = eval;
    bus.i_pc       = pc;
    bus.i_instr    = instr;
  endtask

  // A retired instruction writes only when it has a source and a non-zero destination.
  task automatic check_retire(input string tag, input logic [1:0] src, input logic [4:0] rg,
                              input logic [31:0] data);
    logic exp_en;
    exp_en = (src != DEST_SRC_NONE) && (rg != 5'd0);
    if (exp_en) begin
      last_reg  = rg;
      last_data = data;
    end
    chk({tag, ".en"},     64'(bus.o_dest_en),   64'(exp_en));
    chk({tag, ".retire"}, 64'(bus.o_retire),    64'd1);
    chk({tag, ".reg"},    64'(bus.o_dest_reg),  64'(last_reg));
    chk({tag, ".data"},   64'(bus.o_dest_data), 64'(last_data));
    chk({tag, ".ready"},  64'(bus.o_ready),     64'd1);
  endtask

  task automatic run_load(input string tag, input logic [4:0] rg, input logic [31:0] eval,
                          input logic [2:0] f3, input logic [31:0] rdata, input int wt);
    issue(DEST_SRC_MEM, rg, eval, $urandom, f3);
    step();
    bus.i_valid = 1'b0;
    chk({tag, ".acc_ready"},  64'(bus.o_ready),  64'd0);
    chk({tag, ".acc_retire"}, 64'(bus.o_retire), 64'd0);
    chk({tag, ".acc_en"},     64'(bus.o_dest_en), 64'd0);
    for (int k = 0; k < wt; k++) begin
      step();
      chk({tag, ".wait_ready"}, 64'(bus.o_ready), 64'd0);
    end
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = rdata;
    step();
    bus.i_mem_rvalid = 1'b0;
    check_retire(tag, DEST_SRC_MEM, rg, ref_load(rdata, eval, f3));
  endtask

  initial begin
    logic [1:0]  src;
    logic [4:0]  rg;
    logic [31:0] eval, pc, rdata;
    logic [2:0]  f3;

    bus.i_valid      = 1'b0;
    bus.i_pc         = '0;
    bus.i_instr      = '0;
    bus.i_dest_src   = DEST_SRC_NONE;
    bus.i_dest_reg   = '0;
    bus.i_alu_eval   = '0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;

    #2;
    chk("rst.en",     64'(bus.o_dest_en),   64'd0);
    chk("rst.retire", 64'(bus.o_retire),    64'd0);
    chk("rst.reg",    64'(bus.o_dest_reg),  64'd0);
    chk("rst.data",   64'(bus.o_dest_data), 64'd0);
    chk("rst.ready",  64'(bus.o_ready),     64'd1);
    #10 clr_n = 1'b1;

    issue(DEST_SRC_ALU, 5'd3, 32'h11, 32'h0, 3'd0);
    step();
    check_retire("alu_b2b0", DEST_SRC_ALU, 5'd3, 32'h11);
    issue(DEST_SRC_ALU, 5'd4, 32'h22, 32'h0, 3'd0);
    step();
    bus.i_valid = 1'b0;
    check_retire("alu_b2b1", DEST_SRC_ALU, 5'd4, 32'h22);

    issue(DEST_SRC_LINK, 5'd1, 32'hdead, 32'h100, 3'd0);
    step();
    check_retire("link", DEST_SRC_LINK, 5'd1, 32'h104);
    issue(DEST_SRC_ALU, 5'd0, 32'h55, 32'h0, 3'd0);
    step();
    bus.i_valid = 1'b0;
    check_retire("alu_x0", DEST_SRC_ALU, 5'd0, 32'h55);

    run_load("lb",  5'd7, 32'h1002, 3'b000, 32'h00FF8000, 2);
    chk("lb.value", 64'(bus.o_dest_data), 64'hFFFFFFFF);
    run_load("lbu", 5'd7, 32'h1002, 3'b100, 32'h00FF8000, 2);
    chk("lbu.value", 64'(bus.o_dest_data), 64'h000000FF);
    run_load("lh",  5'd9, 32'h2002, 3'b001, 32'h80000000, 0);
    chk("lh.value", 64'(bus.o_dest_data), 64'hFFFF8000);
    run_load("lhu", 5'd9, 32'h2002, 3'b101, 32'h80000000, 1);
    chk("lhu.value", 64'(bus.o_dest_data), 64'h00008000);

    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h12345678;
    step();
    bus.i_mem_rvalid = 1'b0;
    chk("stray.en",     64'(bus.o_dest_en), 64'd0);
    chk("stray.retire", 64'(bus.o_retire),  64'd0);
    chk("stray.ready",  64'(bus.o_ready),   64'd1);

    for (int i = 0; i < 40; i++) begin
      src   = 2'($urandom_range(0, 3));
      rg    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      eval  = $urandom;
      pc    = $urandom;
      f3    = 3'($urandom_range(0, 7));
      rdata = $urandom;
      if (src == DEST_SRC_MEM) begin
        run_load("rnd_load", rg, eval, f3, rdata, $urandom_range(0, 3));
      end else begin
        issue(src, rg, eval, pc, f3);
        step();
        bus.i_valid = 1'b0;
        check_retire("rnd_op", src, rg, (src == DEST_SRC_LINK) ? pc + 32'd4 : eval);
      end
    end

    issue(DEST_SRC_MEM, 5'd5, 32'h0, 32'h0, 3'b010);
    step();
    bus.i_valid = 1'b0;
    step();
    clr_n = 1'b0;
    #1;
    chk("midrst.en",     64'(bus.o_dest_en),   64'd0);
    chk("midrst.retire", 64'(bus.o_retire),    64'd0);
    chk("midrst.data",   64'(bus.o_dest_data), 64'd0);
    chk("midrst.reg",    64'(bus.o_dest_reg),  64'd0);
    chk("midrst.ready",  64'(bus.o_ready),     64'd1);
    #2 clr_n = 1'b1;
    step();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hCAFEF00D;
    step();
    bus.i_mem_rvalid = 1'b0;
    chk("midrst.late_en",     64'(bus.o_dest_en), 64'd0);
    chk("midrst.late_retire", 64'(bus.o_retire),  64'd0);
    chk("midrst.late_ready",  64'(bus.o_ready),   64'd1);

`ifdef WB_RETIRE_CNT_EN
    clr_n = 1'b0;
    #2;
    chk("cnt.rst", 64'(retire_cnt), 64'd0);
    clr_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      issue(DEST_SRC_NONE, 5'd0, 32'h0, 32'h0, 3'd0);
      step();
      chk("cnt.run", 64'(retire_cnt), 64'((i - 1) % 16));
    end
    bus.i_valid = 1'b0;
    step();
    chk("cnt.wrap", 64'(retire_cnt), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised writeback stage for the b-risc pipeline. Sits after the memory stage and drives the register-file write port.
- Adds to the single-cycle ALU-only writeback:
  - a valid/ready handshake;
  - variable-latency load-data return;
  - byte/half/word load extension;
  - link (PC+4) writeback;
  - x0 write suppression;
  - a per-instruction retire pulse.

Parameters:
- ADDR_W, 32, PC width.
- INSTR_W, 32, instruction width.
- WORD_W, 32, data width; multiple of 8, at least 32.
- REG_IDX_W, 5, register index width.
- CNT_W, 32, retire counter width (used only with WB_RETIRE_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction.
- i_pc  in  ADDR_W  instruction PC.
- i_instr  in  INSTR_W  instruction; funct3 = i_instr[14:12].
- i_dest_src  in  DEST_SRC_W  writeback source select.
- i_dest_reg  in  REG_IDX_W  destination register.
- i_alu_eval  in  WORD_W  ALU result; this is the load address for loads.
- i_mem_rvalid  in  1  load data valid.
- i_mem_rdata  in  WORD_W  aligned memory word.
- o_dest_en  out  1  register write enable (pulse).
- o_dest_reg  out  REG_IDX_W  write index.
- o_dest_data  out  WORD_W  write data.
- o_retire  out  1  instruction-completed pulse.
- o_retire_cnt  out  CNT_W  retired count; exists only with WB_RETIRE_CNT_EN.

Behaviour:
- Interface: one clock, clk. Reset clr_n is asynchronous and active-low.
- Reset values:
  - o_dest_en=0, o_dest_reg=0, o_dest_data=0, o_retire=0, o_retire_cnt=0;
  - FSM returns to IDLE;
  - all captured fields (pc, instr, src, reg, eval) cleared.
- DEST_SRC encoding: NONE=0, ALU=1, MEM=2, LINK=3.
- o_ready is 1 only in IDLE, and it is a function of state only (registered).
- Accept means i_valid & o_ready at a rising edge. At accept, capture pc, instr, dest_src, dest_reg and alu_eval.
- FSM state IDLE:
  - On accept with src NONE, ALU or LINK: stay in IDLE. o_retire=1 during the next cycle.
  - For ALU/LINK with dest_reg!=0: o_dest_en=1 during the next cycle. Data is alu_eval (ALU) or pc+4 truncated to WORD_W (LINK). Latency is 1 cycle, giving back-to-back throughput of 1 per cycle.
  - On accept with src MEM: go to WAIT_MEM. No output pulses.
  - i_mem_rvalid seen in IDLE is ignored.
- FSM state WAIT_MEM:
  - o_ready=0.
  - On an edge with i_mem_rvalid=1: register the extended data, return to IDLE, assert o_retire=1 during the next cycle, and assert o_dest_en=1 if dest_reg!=0.
  - Minimum load occupancy is 2 cycles (accept edge plus rvalid edge). There is no timeout.
- Load extension:
  - lane = alu_eval[$clog2(WORD_W/8)-1:0].
  - LB/LBU (funct3 000/100): byte at lane*8, sign- or zero-extended.
  - LH/LHU (001/101): halfword at lane with bit 0 ignored (lane & ~1), sign- or zero-extended.
  - LW (010): 32 bits at lane & ~3, sign-extended to WORD_W. LWU (110) zero-extends.
  - Any other funct3: full word passed through.
- Timing of outputs:
  - o_dest_en and o_retire are single-cycle pulses.
  - o_dest_reg and o_dest_data hold their last value when o_dest_en=0.
- Reset asserted in WAIT_MEM drops the pending load: no write, no retire.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- When defined: a CNT_W-bit counter increments on each o_retire pulse (the edge ending that cycle) and is exposed on o_retire_cnt. It wraps from 2^CNT_W-1 to 0 and resets to 0.
- When undefined: the counter and the o_retire_cnt port are absent. All other behaviour is identical.

Decomposition:
- Shared package / config.vh:
  - DEST_SRC_W and the DEST_SRC_NONE/ALU/MEM/LINK constants;
  - funct3 load constants LB/LH/LW/LBU/LHU/LWU;
  - WB FSM state encodings.
- One natural sub-module: wb_load_ext. It is purely combinational: (rdata, lane, funct3) -> extended word.

Test Plan:
- ALU back-to-back: accept ALU reg=3 eval=0x11, then reg=4 eval=0x22 on consecutive cycles -> o_dest_en pulses on the next two cycles with (3,0x11),(4,0x22); o_ready stays 1.
- LINK and x0: LINK pc=0x100 reg=1 -> data 0x104, en=1. Then ALU reg=0 -> en=0, o_retire=1.
- Load wait: MEM LB eval=0x...2, rdata=0x00FF8000, rvalid asserted 3 cycles after accept -> o_ready=0 during the wait, then en=1 with data 0xFFFFFFFF. Same load with LBU -> data 0x000000FF.
- LH lane 2 with rdata=0x80000000 -> 0xFFFF8000. LHU -> 0x00008000. Stray rvalid in IDLE -> no output.
- Reset mid-load: clr_n low while in WAIT_MEM -> outputs 0 immediately, o_ready=1 after release; a later rvalid causes no write.
- WB_RETIRE_CNT_EN with CNT_W=4: 17 retires -> o_retire_cnt counts to 15, wraps to 0, then reads 1.
